// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared datapath width and ALU select encoding for pd0
package constants_pkg;

    localparam int DWIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        AND = 2'd2,
        OR  = 2'd3
    } aluSel_e;

endpackage

// File: rtl/pd0_alu.sv
// rtl/pd0_alu.sv - combinational ADD/SUB/AND/OR unit, results wrap modulo 2^DWIDTH
module pd0_alu
    import constants_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  aluSel_e           sel,
    input  logic [DWIDTH-1:0] op1,
    input  logic [DWIDTH-1:0] op2,
    output logic [DWIDTH-1:0] res
);

    always_comb begin
        res = '0;
        case (sel)
            ADD:     res = op1 + op2;
            SUB:     res = op1 - op2;
            AND:     res = op1 & op2;
            OR:      res = op1 | op2;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/pd0_reg.sv
// rtl/pd0_reg.sv - write-enabled register, cleared asynchronously by reset
module pd0_reg
    import constants_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (we) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/pd0_tsp.sv
// rtl/pd0_tsp.sv - two-stage pipeline: register op1+op2 and op1, then subtract to recover op2
module pd0_tsp
    import constants_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] op1,
    input  logic [DWIDTH-1:0] op2,
    output logic [DWIDTH-1:0] res
);

    logic [DWIDTH-1:0] sum;
    logic [DWIDTH-1:0] sum_r;
    logic [DWIDTH-1:0] op1_r;

    pd0_alu #(.DWIDTH(DWIDTH)) u_add (
        .sel (ADD),
        .op1 (op1),
        .op2 (op2),
        .res (sum)
    );

    // No enable: a new operand pair is accepted on every edge out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_r <= '0;
            op1_r <= '0;
        end else begin
            sum_r <= sum;
            op1_r <= op1;
        end
    end

    pd0_alu #(.DWIDTH(DWIDTH)) u_sub (
        .sel (SUB),
        .op1 (sum_r),
        .op2 (op1_r),
        .res (res)
    );

endmodule

// File: rtl/pd0.sv
// rtl/pd0.sv - wires ALU, register and pipeline to internal probe variables
module pd0
    import constants_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input logic clk,
    input logic reset
);

    // Stimulus variables carry no continuous driver so they can be overridden externally.
    aluSel_e           alu_sel = ADD;
    logic [DWIDTH-1:0] alu_op1 = '0;
    logic [DWIDTH-1:0] alu_op2 = '0;
    logic [DWIDTH-1:0] alu_res;

    logic              reg_we = 1'b0;
    logic [DWIDTH-1:0] reg_in = '0;
    logic [DWIDTH-1:0] reg_out;

    logic [DWIDTH-1:0] tsp_op1 = '0;
    logic [DWIDTH-1:0] tsp_op2 = '0;
    logic [DWIDTH-1:0] tsp_res;

    pd0_alu #(.DWIDTH(DWIDTH)) u_alu (
        .sel (alu_sel),
        .op1 (alu_op1),
        .op2 (alu_op2),
        .res (alu_res)
    );

    pd0_reg #(.DWIDTH(DWIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .we    (reg_we),
        .din   (reg_in),
        .dout  (reg_out)
    );

    pd0_tsp #(.DWIDTH(DWIDTH)) u_tsp (
        .clk   (clk),
        .reset (reset),
        .op1   (tsp_op1),
        .op2   (tsp_op2),
        .res   (tsp_res)
    );

endmodule

// File: tb/tb_pd0.sv
// tb/tb_pd0.sv - directed and randomized checks of pd0 ALU, register and pipeline
module tb_pd0;
    import constants_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pd0 #(.DWIDTH(32)) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input int s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            0:       return a + b;
            1:       return a - b;
            2:       return a & b;
            3:       return a | b;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b, exp_res;
        int          s;
        logic [31:0] exp_q[$];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_reg_out", dut.reg_out, 32'h0);
        check("reset_tsp_res", dut.tsp_res, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // ALU directed
        dut.alu_sel = ADD; dut.alu_op1 = 32'd5; dut.alu_op2 = 32'd3; #1;
        check("alu_add", dut.alu_res, 32'd8);
        dut.alu_sel = SUB; #1;
        check("alu_sub", dut.alu_res, 32'd2);
        dut.alu_sel = AND; dut.alu_op1 = 32'hAAAAAAAA; dut.alu_op2 = 32'h0F0F0F0F; #1;
        check("alu_and", dut.alu_res, 32'h0A0A0A0A);
        dut.alu_sel = OR; dut.alu_op1 = 32'h55555555; #1;
        check("alu_or", dut.alu_res, 32'h5F5F5F5F);
        dut.alu_sel = SUB; dut.alu_op1 = 32'h0; dut.alu_op2 = 32'h1; #1;
        check("alu_sub_wrap", dut.alu_res, 32'hFFFFFFFF);

        // ALU random
        for (int i = 0; i < 10; i++) begin
            s = $urandom_range(0, 3);
            a = $urandom;
            b = $urandom;
            dut.alu_sel = aluSel_e'(s[1:0]);
            dut.alu_op1 = a;
            dut.alu_op2 = b;
            #1;
            check($sformatf("alu_rand%0d", i), dut.alu_res, alu_model(s, a, b));
        end

        // Register write then hold
        @(negedge clk);
        dut.reg_we = 1'b1; dut.reg_in = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("reg_write", dut.reg_out, 32'hDEADBEEF);
        @(negedge clk);
        dut.reg_we = 1'b0; dut.reg_in = 32'h12345678;
        @(posedge clk); #1;
        check("reg_hold", dut.reg_out, 32'hDEADBEEF);

        // Asynchronous reset between edges, write attempted while in reset
        @(negedge clk); #2;
        reset = 1'b1; #1;
        check("reg_async_clear", dut.reg_out, 32'h0);
        dut.reg_we = 1'b1; dut.reg_in = 32'h55AA55AA;
        @(posedge clk); #1;
        check("reg_held_in_reset", dut.reg_out, 32'h0);
        @(negedge clk);
        reset = 1'b0; dut.reg_we = 1'b0;
        #1;
        check("reg_after_release", dut.reg_out, 32'h0);
        @(posedge clk); #1;
        check("reg_no_capture_we0", dut.reg_out, 32'h0);

        // TSP directed back-to-back, then hold
        @(negedge clk);
        dut.tsp_op1 = 32'd1; dut.tsp_op2 = 32'd2;
        @(negedge clk);
        check("tsp_b2b_0", dut.tsp_res, 32'd2);
        dut.tsp_op1 = 32'd10; dut.tsp_op2 = 32'd20;
        @(negedge clk);
        check("tsp_b2b_1", dut.tsp_res, 32'd20);
        dut.tsp_op1 = 32'hFFFFFFFF; dut.tsp_op2 = 32'd1;
        @(negedge clk);
        check("tsp_wrap_res", dut.tsp_res, 32'd1);
        check("tsp_wrap_sum", dut.u_tsp.sum_r, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("tsp_hold%0d", i), dut.tsp_res, 32'd1);
        end

        // TSP random stream against a queue of expected op2 values
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() > 0) begin
                exp_res = exp_q.pop_front();
                check($sformatf("tsp_rand%0d", i), dut.tsp_res, exp_res);
            end
            a = $urandom;
            b = $urandom;
            dut.tsp_op1 = a;
            dut.tsp_op2 = b;
            exp_q.push_back(b);
            @(negedge clk);
        end
        exp_res = exp_q.pop_front();
        check("tsp_rand_last", dut.tsp_res, exp_res);

        // Reset mid-pipeline discards in-flight data
        dut.tsp_op1 = 32'd3; dut.tsp_op2 = 32'd7;
        @(posedge clk); #2;
        reset = 1'b1; #1;
        check("tsp_reset_immediate", dut.tsp_res, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("tsp_in_reset", dut.tsp_res, 32'h0);
        end
        reset = 1'b0; #1;
        check("tsp_after_release", dut.tsp_res, 32'h0);
        @(negedge clk);
        check("tsp_first_capture", dut.tsp_res, 32'd7);

        // ALU unaffected by reset
        reset = 1'b1;
        dut.alu_sel = ADD; dut.alu_op1 = 32'd100; dut.alu_op2 = 32'd23; #1;
        check("alu_in_reset", dut.alu_res, 32'd123);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
